// File: rtl/alu_muldiv.sv
// ============================================================================
// Module      : alu_muldiv
// Description : Registered integer ALU with iterative RV32M/RV64M mul/div/rem
//               and valid/ready handshake on both sides.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv #(
  parameter int XLEN     = 32,
  parameter int SHAMT_W  = $clog2(XLEN),
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_data1,
  input  logic [XLEN-1:0] in_data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] c_mul_steps = CNT_W'(XLEN / MUL_BITS);
  localparam logic [CNT_W-1:0] c_div_steps = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_four      = XLEN'(4);
  localparam logic [XLEN-1:0]  c_min_neg   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q;
  logic [XLEN-1:0]     result_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     quo_q;
  logic [XLEN-1:0]     divisor_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic                sel_q;

  logic                w_accept;
  logic                w_is_md;
  logic                w_is_div;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [XLEN-1:0]     w_base;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic [XLEN-1:0]     w_special;
  logic [2*XLEN-1:0]   w_pp;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_prod_fin;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_diff;
  logic                w_ge;
  logic [XLEN-1:0]     w_rem_next;
  logic [XLEN-1:0]     w_quo_next;
  logic [XLEN-1:0]     w_div_res;

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
  assign out_result = result_q;

  assign w_accept = in_valid && in_ready && !flush;
  assign w_is_md  = (in_op[4:3] == 2'b10);
  assign w_is_div = w_is_md && in_op[2];
  assign w_shamt  = in_data2[SHAMT_W-1:0];

  always_comb begin
    w_base = in_data2;
    case (in_op)
      5'd0:    w_base = in_data1 + in_data2;
      5'd1:    w_base = in_data1 << w_shamt;
      5'd2:    w_base = {{(XLEN-1){1'b0}}, ($signed(in_data1) < $signed(in_data2))};
      5'd3:    w_base = {{(XLEN-1){1'b0}}, (in_data1 < in_data2)};
      5'd4:    w_base = in_data1 ^ in_data2;
      5'd5:    w_base = in_data1 >> w_shamt;
      5'd6:    w_base = in_data1 | in_data2;
      5'd7:    w_base = in_data1 & in_data2;
      5'd8:    w_base = in_data1 - in_data2;
      5'd9:    w_base = $unsigned($signed(in_data1) >>> w_shamt);
      5'd10:   w_base = in_data1 + c_four;
      default: w_base = in_data2;
    endcase
  end

  // Mul: MULHU is the only fully unsigned op, MULHSU leaves rs2 unsigned.
  // Div: bit 0 of the op selects the unsigned variants.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    if (w_is_div) begin
      w_a_signed = !in_op[0];
      w_b_signed = !in_op[0];
    end else begin
      w_a_signed = (in_op[1:0] != 2'b11);
      w_b_signed = !in_op[1];
    end
  end

  assign w_a_neg = w_a_signed && in_data1[XLEN-1];
  assign w_b_neg = w_b_signed && in_data2[XLEN-1];
  assign w_a_mag = w_a_neg ? (-in_data1) : in_data1;
  assign w_b_mag = w_b_neg ? (-in_data2) : in_data2;

  assign w_div_zero = (in_data2 == '0);
  assign w_div_ovf  = !in_op[0] && (in_data1 == c_min_neg) && (in_data2 == '1);

  always_comb begin
    w_special = '0;
    if (w_div_zero) begin
      w_special = in_op[1] ? in_data1 : '1;
    end else begin
      w_special = in_op[1] ? '0 : in_data1;
    end
  end

  // Shift-add on magnitudes; sign is applied once to the full product.
  assign w_pp       = mcand_q * {{(2*XLEN-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
  assign w_acc_next = acc_q + w_pp;
  assign w_prod_fin = neg_q ? (-w_acc_next) : w_acc_next;
  assign w_mul_res  = sel_q ? w_prod_fin[2*XLEN-1:XLEN] : w_prod_fin[XLEN-1:0];

  // Restoring step: the shifted partial remainder is below 2*divisor,
  // so bit XLEN of the difference is a reliable borrow flag.
  assign w_rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, divisor_q};
  assign w_ge       = !w_diff[XLEN];
  assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_next = {quo_q[XLEN-2:0], w_ge};
  assign w_div_res  = sel_q ? (neg_q ? (-w_rem_next) : w_rem_next)
                            : (neg_q ? (-w_quo_next) : w_quo_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      sel_q     <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (!w_is_md) begin
              result_q <= w_base;
              state_q  <= S_DONE;
            end else if (!w_is_div) begin
              acc_q    <= '0;
              mcand_q  <= {{XLEN{1'b0}}, w_a_mag};
              mplier_q <= w_b_mag;
              cnt_q    <= c_mul_steps;
              neg_q    <= w_a_neg ^ w_b_neg;
              sel_q    <= (in_op[1:0] != 2'b00);
              state_q  <= S_MUL;
            end else if (w_div_zero || w_div_ovf) begin
              result_q <= w_special;
              state_q  <= S_DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= w_a_mag;
              divisor_q <= w_b_mag;
              cnt_q     <= c_div_steps;
              neg_q     <= in_op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
              sel_q     <= in_op[1];
              state_q   <= S_DIV;
            end
          end else if (state_q == S_DONE && out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q    <= w_acc_next;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          cnt_q    <= cnt_q - c_cnt_one;
          if (cnt_q == c_cnt_one) begin
            result_q <= w_mul_res;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          rem_q <= w_rem_next;
          quo_q <= w_quo_next;
          cnt_q <= cnt_q - c_cnt_one;
          if (cnt_q == c_cnt_one) begin
            result_q <= w_div_res;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Directed self-checking bench for alu_muldiv (XLEN=32).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_muldiv;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_data1;
  logic [31:0] in_data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int bcnt;

  alu_muldiv #(.XLEN(32), .MUL_BITS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for one cycle, then scramble the operand buses.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_data1 = a;
    in_data2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data1 = $urandom;
    in_data2 = $urandom;
  endtask

  task automatic wait_result(input int max, output int l, output int b);
    l = 1;
    b = 0;
    while (!out_valid && l < max) begin
      if (busy) b++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    issue(op, a, b);
    wait_result(100, lat, bcnt);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, out_result, exp);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 5'd0;
    in_data1  = '0;
    in_data2  = '0;
    out_ready = 1'b1;
    #23;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_result",    out_result,         32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add",    5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
    run_op("sra",    5'd9,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
    run_op("sltu",   5'd3,  32'h1,         32'hFFFF_FFFF, 32'h1,         1);
    run_op("slt",    5'd2,  32'h1,         32'hFFFF_FFFF, 32'h0,         1);
    run_op("op31",   5'd31, 32'hDEAD_BEEF, 32'h1234,      32'h1234,      1);
    run_op("add4",   5'd10, 32'h100,       32'h0,         32'h104,       1);

    run_op("mulh",   5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33);
    check("mul_busy_cycles", 32'(bcnt), 32'd32);
    run_op("mulhu",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul",    5'd16, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
    run_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);

    run_op("div",    5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",    5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",   5'd21, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu",   5'd23, 32'd100,       32'd7,         32'd2,         33);
    run_op("rem_pn", 5'd22, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);

    run_op("div_z",   5'd20, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_z",  5'd23, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    // Backpressure on a completed MUL, then a back-to-back base-op stream.
    issue(5'd16, 32'd6, 32'd7);
    out_ready = 1'b0;
    wait_result(100, lat, bcnt);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  {31'd0, out_valid}, 32'd1);
      check("bp_result", out_result,         32'd42);
      check("bp_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    begin
      logic [4:0]  s_op  [4] = '{5'd0, 5'd4, 5'd8, 5'd1};
      logic [31:0] s_a   [4] = '{32'd1, 32'hF0, 32'd5, 32'h1};
      logic [31:0] s_b   [4] = '{32'd2, 32'hFF, 32'd7, 32'h21};
      logic [31:0] s_exp [4] = '{32'd3, 32'h0F, 32'hFFFF_FFFE, 32'h2};
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1;
        in_op    = s_op[i];
        in_data1 = s_a[i];
        in_data2 = s_b[i];
        @(posedge clk); #1;
        check("stream_valid",  {31'd0, out_valid}, 32'd1);
        check("stream_result", out_result,         s_exp[i]);
      end
      in_valid = 1'b0;
    end
    @(posedge clk); #1;

    // Flush during a DIV; the op presented alongside flush must be dropped.
    issue(5'd21, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 5'd0;
    in_data1 = 32'd1;
    in_data2 = 32'd1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready},  32'd1);
    check("flush_busy",  {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a MUL, between clock edges.
    issue(5'd16, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'd0, busy},      32'd0);
    check("arst_valid",  {31'd0, out_valid}, 32'd0);
    check("arst_ready",  {31'd0, in_ready},  32'd1);
    check("arst_result", out_result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_and", 5'd7, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, registered successor to the combinational integer ALU.
- Executes the base ALU operation set plus the RV32M/RV64M multiply/divide/remainder operations.
- Uses a valid/ready handshake on input and output, so the execute stage can stall on multi-cycle operations.
- Sits in the EX stage between operand forwarding and the EX/MEM pipeline register.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN), number of low bits of data2 used as the shift amount.
- MUL_BITS, 1, multiplier bits retired per cycle (1, 2 or 4); must divide XLEN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  pipeline flush; aborts any operation in flight
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept an operation this cycle
- in_op  in  5  operation code (encoding below)
- in_data1  in  XLEN  operand 1 (rs1/PC)
- in_data2  in  XLEN  operand 2 (rs2/immediate)
- out_valid  out  1  out_result holds a completed result
- out_ready  in  1  downstream accepts the result
- out_result  out  XLEN  result
- busy  out  1  iterative operation in progress

Behaviour:
- Op encoding: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA, 10 ADD4 (data1+4), 11 BPS2 (pass data2), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Any other code behaves as BPS2.
- Arithmetic rules:
  - All arithmetic is modulo 2^XLEN.
  - Shifts use in_data2[SHAMT_W-1:0] only.
  - SRA replicates in_data1[XLEN-1].
  - SLT/SLTU return 0 or 1, zero-extended.
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_result=0, busy=0, in_ready=1; all internal accumulators and counters are cleared.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_result is held stable while out_valid && !out_ready.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, accept base op -> DONE. The result is registered, giving 1-cycle latency (out_valid on the cycle after acceptance).
  - IDLE, accept MUL* -> MUL. The multiplicand/multiplier are sign-adjusted per op, and the counter is loaded with XLEN/MUL_BITS.
  - IDLE, accept DIV*/REM* with a special case -> DONE directly (1-cycle latency). Special cases:
    - divisor 0: DIV/DIVU result all-ones; REM/REMU result = dividend.
    - signed overflow (DIV/REM with dividend = -2^(XLEN-1) and divisor = -1): DIV result = dividend; REM result = 0.
  - IDLE, accept DIV*/REM* otherwise -> DIV. Operands are converted to magnitudes, and the counter is loaded with XLEN.
  - MUL: shift-add MUL_BITS per cycle; when the counter reaches 0 -> DONE. MUL selects the low XLEN bits; MULH, MULHSU and MULHU select the high XLEN bits of the signed/signed, signed/unsigned and unsigned/unsigned 2*XLEN-bit product. Latency XLEN/MUL_BITS+1 cycles.
  - DIV: restoring division, 1 quotient bit per cycle; when the counter reaches 0 -> DONE. Quotient sign = sign(a) xor sign(b); remainder sign = sign(dividend). Latency XLEN+1 cycles.
  - DONE, out_ready=1: return to IDLE, or accept a new op in the same cycle (back-to-back base ops sustain 1 op/cycle).
  - DONE, out_ready=0: hold.
- busy = (state==MUL || state==DIV).
- Flush: synchronous, highest priority after reset. Next state=IDLE and out_valid=0, any in-flight or held result is discarded, and an op presented with flush in the same cycle is not accepted.
- Operands are captured at acceptance; later changes on in_data* do not affect an op in flight.

Test Plan:
- Reset/base ops: after rst_n deassert, ADD 0x7FFFFFFF+1 -> 0x80000000 one cycle later; SRA 0x80000000 by 0x24 -> 0xF8000000 (shift 4); SLTU 1,0xFFFFFFFF -> 1; in_op=31 with data2=0x1234 -> 0x1234.
- Multiply (XLEN=32, MUL_BITS=1): MULH -1*-1 -> 0; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL 3*-5 -> 0xFFFFFFF1; out_valid exactly 33 cycles after acceptance; busy high for 32 cycles.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; latency 33 cycles.
- Division special cases: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0; each completes in 1 cycle.
- Backpressure/throughput: out_ready=0 for 5 cycles after a completed MUL -> out_result stable and in_ready=0; then stream 4 base ops with out_ready=1 -> 4 results on 4 consecutive cycles.
- Flush/reset mid-op: flush at cycle 10 of a DIV -> no out_valid, in_ready=1 the next cycle; rst_n pulse low during a MUL -> all outputs return to reset values immediately, without waiting for a clock edge.
